// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
// Receive-side TMDS channel: word alignment through deserializer bitslip, plus
// token/data decode behind a two-stage pipeline (classify, then output register).
// Optional statistics ports (o_slip_count, o_unlock_count) exist only when the
// macro TMDS_STATS_EN is defined.
module tmds_channel_decoder #(
    parameter int LOCK_TOKENS  = 8,
    parameter int SEARCH_WORDS = 2048,
    parameter int SLIP_WAIT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [9:0] i_q,
    output logic       o_bitslip,
    output logic       o_locked,
    output logic       o_valid,
    output logic       o_data_en,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl
`ifdef TMDS_STATS_EN
    ,
    output logic [7:0] o_slip_count,
    output logic [7:0] o_unlock_count
`endif
);

    localparam int CNT_MAX_A = (SEARCH_WORDS > SLIP_WAIT) ? SEARCH_WORDS : SLIP_WAIT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TOKENS) ? CNT_MAX_A : LOCK_TOKENS;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_TOKENS);
    localparam logic [CW-1:0] WORD_LAST  = CW'(SEARCH_WORDS - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(SLIP_WAIT - 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_SLIP   = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    // Stage-0 combinational classification of the incoming word
    logic       tok_hit;
    logic [1:0] tok_ctrl;
    logic [7:0] dbar;
    logic [7:0] dec;

    // Stage-1 registers
    logic       s1_valid_q, s1_valid_d;
    logic       s1_token_q, s1_token_d;
    logic [1:0] s1_ctrl_q,  s1_ctrl_d;
    logic [7:0] s1_data_q,  s1_data_d;

    // Alignment state
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] run_q,   run_d;
    logic [CW-1:0] word_q,  word_d;
    logic [CW-1:0] wait_q,  wait_d;
    logic [CW-1:0] run_next;
    logic          tok_seen;
    logic          data_seen;

    // Output registers
    logic       o_bitslip_q, o_bitslip_d;
    logic       o_locked_q,  o_locked_d;
    logic       o_valid_q,   o_valid_d;
    logic       o_data_en_q, o_data_en_d;
    logic [7:0] o_data_q,    o_data_d;
    logic [1:0] o_ctrl_q,    o_ctrl_d;

    // Token lookup and transition-minimised data decode of the raw word
    always_comb begin
        tok_hit  = 1'b1;
        tok_ctrl = 2'b00;
        unique case (i_q)
            TOK_00:  tok_ctrl = 2'b00;
            TOK_01:  tok_ctrl = 2'b01;
            TOK_10:  tok_ctrl = 2'b10;
            TOK_11:  tok_ctrl = 2'b11;
            default: tok_hit  = 1'b0;
        endcase

        dbar   = i_q[9] ? ~i_q[7:0] : i_q[7:0];
        dec    = '0;
        dec[0] = dbar[0];
        for (int unsigned i = 1; i < 8; i++) begin
            dec[i] = i_q[8] ? (dbar[i] ^ dbar[i-1]) : ~(dbar[i] ^ dbar[i-1]);
        end
    end

    // Stage 1: capture classification; control value persists until the next token
    always_comb begin
        s1_valid_d = i_valid;
        s1_token_d = s1_token_q;
        s1_ctrl_d  = s1_ctrl_q;
        s1_data_d  = s1_data_q;
        if (i_valid) begin
            s1_token_d = tok_hit;
            s1_data_d  = tok_hit ? 8'h00 : dec;
            if (tok_hit) begin
                s1_ctrl_d = tok_ctrl;
            end
        end
    end

    // Alignment FSM: token-run detection, search timeout, slip and settle
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        word_d    = word_q;
        wait_d    = wait_q;
        tok_seen  = s1_valid_q & s1_token_q;
        data_seen = s1_valid_q & ~s1_token_q;

        run_next = run_q;
        if (tok_seen && (run_q != LOCK_LIMIT)) begin
            run_next = run_q + 1'b1;
        end else if (data_seen) begin
            run_next = '0;
        end

        case (state_q)
            ST_SEARCH: begin
                run_d = run_next;
                if (s1_valid_q) begin
                    // Lock takes priority over a coincident search timeout
                    if (run_next == LOCK_LIMIT) begin
                        state_d = ST_LOCKED;
                        word_d  = '0;
                    end else if (word_q == WORD_LAST) begin
                        state_d = ST_SLIP;
                        word_d  = '0;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            ST_SLIP: begin
                state_d = ST_WAIT;
                run_d   = '0;
                word_d  = '0;
                wait_d  = '0;
            end
            ST_WAIT: begin
                run_d = '0;
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_SEARCH;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                run_d = run_next;
                if (tok_seen) begin
                    word_d = '0;
                end else if (data_seen) begin
                    if (word_q == WORD_LAST) begin
                        state_d = ST_SEARCH;
                        word_d  = '0;
                        run_d   = '0;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_SEARCH;
                run_d   = '0;
                word_d  = '0;
                wait_d  = '0;
            end
        endcase
    end

    // Stage 2: output register; validity follows the next lock state so that
    // o_valid rises and falls in the same cycle as o_locked
    always_comb begin
        o_bitslip_d = (state_d == ST_SLIP);
        o_locked_d  = (state_d == ST_LOCKED);
        o_valid_d   = s1_valid_q & (state_d == ST_LOCKED);
        o_data_en_d = o_data_en_q;
        o_data_d    = o_data_q;
        o_ctrl_d    = o_ctrl_q;
        if (o_valid_d) begin
            o_data_en_d = ~s1_token_q;
            o_data_d    = s1_data_q;
            o_ctrl_d    = s1_ctrl_q;
        end
    end

    // Register update for pipeline, FSM and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_token_q  <= 1'b0;
            s1_ctrl_q   <= 2'b00;
            s1_data_q   <= 8'h00;
            state_q     <= ST_SEARCH;
            run_q       <= '0;
            word_q      <= '0;
            wait_q      <= '0;
            o_bitslip_q <= 1'b0;
            o_locked_q  <= 1'b0;
            o_valid_q   <= 1'b0;
            o_data_en_q <= 1'b0;
            o_data_q    <= 8'h00;
            o_ctrl_q    <= 2'b00;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_token_q  <= s1_token_d;
            s1_ctrl_q   <= s1_ctrl_d;
            s1_data_q   <= s1_data_d;
            state_q     <= state_d;
            run_q       <= run_d;
            word_q      <= word_d;
            wait_q      <= wait_d;
            o_bitslip_q <= o_bitslip_d;
            o_locked_q  <= o_locked_d;
            o_valid_q   <= o_valid_d;
            o_data_en_q <= o_data_en_d;
            o_data_q    <= o_data_d;
            o_ctrl_q    <= o_ctrl_d;
        end
    end

    assign o_bitslip = o_bitslip_q;
    assign o_locked  = o_locked_q;
    assign o_valid   = o_valid_q;
    assign o_data_en = o_data_en_q;
    assign o_data    = o_data_q;
    assign o_ctrl    = o_ctrl_q;

`ifdef TMDS_STATS_EN
    logic [7:0] slip_cnt_q,   slip_cnt_d;
    logic [7:0] unlock_cnt_q, unlock_cnt_d;

    // Saturating counts of bitslip pulses and lock losses
    always_comb begin
        slip_cnt_d   = slip_cnt_q;
        unlock_cnt_d = unlock_cnt_q;
        if (o_bitslip_d && (slip_cnt_q != 8'hFF)) begin
            slip_cnt_d = slip_cnt_q + 8'd1;
        end
        if ((state_q == ST_LOCKED) && (state_d == ST_SEARCH) && (unlock_cnt_q != 8'hFF)) begin
            unlock_cnt_d = unlock_cnt_q + 8'd1;
        end
    end

    // Statistics registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            slip_cnt_q   <= 8'h00;
            unlock_cnt_q <= 8'h00;
        end else begin
            slip_cnt_q   <= slip_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
        end
    end

    assign o_slip_count   = slip_cnt_q;
    assign o_unlock_count = unlock_cnt_q;
`endif

endmodule
